// File: rtl/lcd_fb_pkg.sv
// Shared definitions for the LCD frame-buffer streamer: FSM states, default geometry
// and the width helper used for the address, page, column and chip fields.
package lcd_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DONE
  } fb_state_e;

  localparam int unsigned DEF_NUM_CHIPS = 2;
  localparam int unsigned DEF_PAGES     = 8;
  localparam int unsigned DEF_COLS      = 64;

  // A field always needs at least one bit, even when it can only ever hold 0.
  function automatic int unsigned fb_addr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// Simple dual-port synchronous byte RAM: one write port, one read port with read enable.
// A read of the address being written in the same cycle returns the old contents.
module lcd_fb_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The read register holds while i_re is low so a stalled byte stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_fb_streamer.sv
// Frame-buffer source for a multi-chip KS0108-class LCD: host write port, page/chip/column readout.
// Build option LCD_FB_DOUBLE_BUFFER_EN: front/back buffers, swap applied only at frame boundaries.
module lcd_fb_streamer
  import lcd_fb_pkg::*;
#(
  parameter int unsigned NUM_CHIPS    = DEF_NUM_CHIPS,
  parameter int unsigned PAGES        = DEF_PAGES,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned AUTO_REFRESH = 0,
  localparam int unsigned AW = fb_addr_width(NUM_CHIPS * PAGES * COLS),
  localparam int unsigned PW = fb_addr_width(PAGES),
  localparam int unsigned CW = fb_addr_width(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 refresh,
  input  logic                 swap,
  input  logic                 en_tran,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  output logic [PW-1:0]        page,
  output logic [CW-1:0]        col,
  output logic [NUM_CHIPS-1:0] chip_sel,
  output logic                 seg_start,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 front_sel
);

  localparam int unsigned KW = fb_addr_width(NUM_CHIPS);
`ifdef LCD_FB_DOUBLE_BUFFER_EN
  localparam int unsigned NBUF = 2;
`else
  localparam int unsigned NBUF = 1;
`endif
  localparam int unsigned RAW = AW + NBUF - 1;

  fb_state_e            r_state;
  logic [PW-1:0]        r_page;
  logic [CW-1:0]        r_col;
  logic [KW-1:0]        r_chip;
  logic [NUM_CHIPS-1:0] r_chip_sel;
  logic                 r_seg_start;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ref_pend;
  logic                 r_front_sel;

  logic [AW-1:0]        w_lin;
  logic [RAW-1:0]       w_raddr;
  logic [RAW-1:0]       w_waddr;
  logic [7:0]           w_rdata;
  logic [NUM_CHIPS-1:0] w_chip_onehot;
  logic                 w_accept;
  logic                 w_last;

  assign w_lin = AW'((32'(r_page) * NUM_CHIPS + 32'(r_chip)) * COLS + 32'(r_col));
  assign w_chip_onehot = NUM_CHIPS'(1) << r_chip;
  assign w_accept = r_valid & en_tran;
  assign w_last = (r_col == CW'(COLS - 1)) && (r_chip == KW'(NUM_CHIPS - 1)) &&
                  (r_page == PW'(PAGES - 1));

`ifdef LCD_FB_DOUBLE_BUFFER_EN
  logic r_swap_pend;
  logic w_swap_apply;

  assign w_raddr = {r_front_sel, w_lin};
  assign w_waddr = {~r_front_sel, wr_addr};
  // Frame boundaries: idle, the done cycle, or the edge that accepts the last byte.
  assign w_swap_apply = r_swap_pend &
                        ((r_state == IDLE) || (r_state == DONE) || (w_accept && w_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front_sel <= 1'b0;
      r_swap_pend <= 1'b0;
    end else if (w_swap_apply) begin
      r_front_sel <= ~r_front_sel;
      r_swap_pend <= swap;
    end else if (swap) begin
      r_swap_pend <= 1'b1;
    end
  end
`else
  logic w_unused_swap;

  assign w_raddr       = w_lin;
  assign w_waddr       = wr_addr;
  assign r_front_sel   = 1'b0;
  assign w_unused_swap = swap;
`endif

  lcd_fb_ram #(
    .DEPTH(NBUF * NUM_CHIPS * PAGES * COLS),
    .AW   (RAW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (wr_en),
    .i_waddr(w_waddr),
    .i_wdata(wr_data),
    .i_re   (r_state == FETCH),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_page      <= '0;
      r_col       <= '0;
      r_chip      <= '0;
      r_chip_sel  <= '0;
      r_seg_start <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ref_pend  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (refresh) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_state     <= VALID;
          r_valid     <= 1'b1;
          r_seg_start <= (r_col == '0);
          r_chip_sel  <= w_chip_onehot;
        end
        VALID: begin
          if (en_tran) begin
            r_valid     <= 1'b0;
            r_seg_start <= 1'b0;
            r_chip_sel  <= '0;
            if (r_col == CW'(COLS - 1)) begin
              r_col <= '0;
              if (r_chip == KW'(NUM_CHIPS - 1)) begin
                r_chip <= '0;
                r_page <= (r_page == PW'(PAGES - 1)) ? '0 : r_page + 1'b1;
              end else begin
                r_chip <= r_chip + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          if (r_ref_pend || refresh || (AUTO_REFRESH != 0)) begin
            r_state <= FETCH;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // One-deep request memory; DONE consumes it, so a request arriving in DONE is taken there too.
      if (r_state == DONE)                  r_ref_pend <= 1'b0;
      else if (r_state != IDLE && refresh)  r_ref_pend <= 1'b1;
    end
  end

  assign data_out   = w_rdata;
  assign data_valid = r_valid;
  assign page       = r_page;
  assign col        = r_col;
  assign chip_sel   = r_chip_sel;
  assign seg_start  = r_seg_start;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign front_sel  = r_front_sel;

endmodule

// File: tb/tb_lcd_fb_streamer.sv
// Bench for lcd_fb_streamer: randomized handshake stimulus checked against an array/arithmetic model.
// Works in both builds (LCD_FB_DOUBLE_BUFFER_EN defined or not).
`timescale 1ns/1ps
module tb_lcd_fb_streamer;

  localparam int NC = 2, PG = 8, CL = 64, NB = NC * PG * CL;
  localparam int ANB = 16;  // auto-refresh instance: 2 chips x 2 pages x 4 cols
`ifdef LCD_FB_DOUBLE_BUFFER_EN
  localparam int DB = 1;
`else
  localparam int DB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr_en, refresh, swap, en_tran;
  logic [9:0] wr_addr;
  logic [7:0] wr_data, data_out;
  logic       data_valid, seg_start, busy, frame_done, front_sel;
  logic [2:0] page;
  logic [5:0] col;
  logic [1:0] chip_sel;

  logic       a_wr_en, a_refresh, a_swap, a_en_tran;
  logic [3:0] a_wr_addr;
  logic [7:0] a_wr_data, a_data_out;
  logic       a_data_valid, a_seg_start, a_busy, a_frame_done, a_front_sel;
  logic [0:0] a_page;
  logic [1:0] a_col, a_chip_sel;

  lcd_fb_streamer #(.NUM_CHIPS(NC), .PAGES(PG), .COLS(CL), .AUTO_REFRESH(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh(refresh), .swap(swap), .en_tran(en_tran), .data_out(data_out),
    .data_valid(data_valid), .page(page), .col(col), .chip_sel(chip_sel),
    .seg_start(seg_start), .busy(busy), .frame_done(frame_done), .front_sel(front_sel));

  lcd_fb_streamer #(.NUM_CHIPS(2), .PAGES(2), .COLS(4), .AUTO_REFRESH(1)) dut_auto (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .refresh(a_refresh), .swap(a_swap), .en_tran(a_en_tran), .data_out(a_data_out),
    .data_valid(a_data_valid), .page(a_page), .col(a_col), .chip_sel(a_chip_sel),
    .seg_start(a_seg_start), .busy(a_busy), .frame_done(a_frame_done), .front_sel(a_front_sel));

  int checks = 0, errors = 0;
  logic [7:0] mem [2][NB];
  logic [7:0] amem [2][ANB];
  int mfront = 0, afront = 0;
  int cyc = 0, fd_cnt = 0, fd_cyc = -100;
  logic fd_front = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
      fd_front = front_sel;
    end
  end

  task automatic fill(input int mode);
    int wb;
    wb = (DB != 0) ? 1 - mfront : 0;
    for (int i = 0; i < NB; i++) begin
      logic [7:0] d;
      case (mode)
        0:       d = 8'(i);
        1:       d = 8'($urandom);
        default: d = 8'hAA;
      endcase
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = d;
      mem[wb][i] = d;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (DB != 0) mfront = 1 - mfront;
    checks++;
    if (front_sel !== 1'(mfront)) begin
      errors++;
      $display("FAIL idle_swap front_sel got %b expected %b", front_sel, 1'(mfront));
    end
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Streams one frame from byte 0, checking each accepted byte against the model.
  task automatic stream_frame(input int stall_pct, input int pa, input int pb, input int ps,
                              input int abort_at, output int first_cyc, output int last_cyc);
    int k, budget;
    logic en, stalled, pa_f, pb_f, ps_f;
    logic [20:0] obs, prev, exp;
    k = 0; budget = 0; stalled = 0; pa_f = 0; pb_f = 0; ps_f = 0; prev = '0;
    first_cyc = -1; last_cyc = -1;
    while (k < NB) begin
      @(negedge clk);
      refresh = 1'b0;
      swap = 1'b0;
      budget++;
      if (budget > 20 * NB) begin
        errors++; checks++;
        $display("FAIL stream_timeout got %0d bytes expected %0d", k, NB);
        break;
      end
      obs = {data_valid, data_out, page, col, chip_sel, seg_start};
      if (stalled) begin
        checks++;
        if (obs !== prev) begin
          errors++;
          $display("FAIL stall_stable byte %0d got %h expected %h", k, obs, prev);
        end
      end
      if (k == abort_at) begin
        en_tran = 1'b0;
        return;
      end
      if (k == pa && !pa_f) begin refresh = 1'b1; pa_f = 1; end
      if (k == pb && !pb_f) begin refresh = 1'b1; pb_f = 1; end
      if (k == ps && !ps_f) begin swap = 1'b1; ps_f = 1; end
      en = ($urandom_range(99) >= stall_pct);
      en_tran = en;
      if (data_valid === 1'b1 && en) begin
        int pg, ch, cl;
        pg = k / (NC * CL); ch = (k / CL) % NC; cl = k % CL;
        exp = {1'b1, mem[mfront][k], 3'(pg), 6'(cl), 2'(1 << ch), cl == 0};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL byte %0d got %h expected %h", k, obs, exp);
        end
        if (k == 0) first_cyc = cyc;
        last_cyc = cyc;
        k++;
      end
      stalled = (data_valid === 1'b1) && !en;
      prev = obs;
    end
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    en_tran = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] all;
    rst_n = 1'b0;
    idle_wait(3);
    all = {data_out, data_valid, page, col, chip_sel, seg_start, busy, frame_done, front_sel};
    checks++;
    if (all !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 000000", all);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_stream();
    int fd0, f, l;
    fd0 = fd_cnt;
    pulse_refresh();
    checks++;
    if ({busy, data_valid} !== 2'b10) begin
      errors++;
      $display("FAIL latency_busy got busy/valid %b%b expected 10", busy, data_valid);
    end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_valid got %b expected 1", data_valid);
    end
    stream_frame(0, -1, -1, -1, -1, f, l);
    checks++;
    if (l - f != 2 * (NB - 1)) begin
      errors++;
      $display("FAIL throughput got %0d cycles expected %0d", l - f, 2 * (NB - 1));
    end
    idle_wait(4);
    checks++;
    if (fd_cnt - fd0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end got done=%0d busy=%b expected done=1 busy=0", fd_cnt - fd0, busy);
    end
  endtask

  task automatic test_random_stall();
    int fd0, f, l;
    fill(1);
    fd0 = fd_cnt;
    pulse_refresh();
    stream_frame(50, -1, -1, -1, -1, f, l);
    idle_wait(4);
    checks++;
    if (fd_cnt - fd0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_frame_end got done=%0d busy=%b expected done=1 busy=0", fd_cnt - fd0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int fd0, f, l, f2;
    fd0 = fd_cnt;
    pulse_refresh();
    stream_frame(30, 100, 600, -1, -1, f, l);
    stream_frame(0, -1, -1, -1, -1, f2, l);
    checks++;
    if (f2 - fd_cyc != 2) begin
      errors++;
      $display("FAIL back_to_back gap got %0d expected 2", f2 - fd_cyc);
    end
    idle_wait(6);
    checks++;
    if (fd_cnt - fd0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL merged_refresh got frames=%0d busy=%b expected frames=2 busy=0", fd_cnt - fd0, busy);
    end
  endtask

  task automatic test_abort();
    int fd0, f, l;
    logic [23:0] all;
    pulse_refresh();
    stream_frame(20, -1, -1, -1, 300, f, l);
    fd0 = fd_cnt;
    rst_n = 1'b0;
    #1;
    all = {data_out, data_valid, page, col, chip_sel, seg_start, busy, frame_done, front_sel};
    checks++;
    if (all !== 24'd0) begin
      errors++;
      $display("FAIL async_reset got %h expected 000000", all);
    end
    mfront = 0;
    afront = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_wait(3);
    checks++;
    if (fd_cnt != fd0) begin
      errors++;
      $display("FAIL abort_no_done got %0d expected 0", fd_cnt - fd0);
    end
    pulse_refresh();
    stream_frame(0, -1, -1, -1, -1, f, l);
    idle_wait(4);
  endtask

  task automatic test_swap();
    int f, l;
    fill(2);
    pulse_refresh();
    stream_frame(10, -1, -1, 500, -1, f, l);
    idle_wait(4);
    if (DB != 0) mfront = 1 - mfront;
    checks++;
    if (fd_front !== 1'(mfront) || front_sel !== 1'(mfront)) begin
      errors++;
      $display("FAIL swap_at_done got %b/%b expected %b", fd_front, front_sel, 1'(mfront));
    end
    pulse_refresh();
    stream_frame(20, -1, -1, -1, -1, f, l);
    idle_wait(4);
  endtask

  task automatic afill();
    int wb;
    wb = (DB != 0) ? 1 - afront : 0;
    for (int i = 0; i < ANB; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 8'($urandom);
      amem[wb][i] = a_wr_data;
      @(negedge clk);
    end
    a_wr_en = 1'b0;
  endtask

  task automatic test_auto();
    int k, dones, budget;
    logic [13:0] obs, exp;
    afill();
    a_swap = 1'b1;
    @(negedge clk);
    a_swap = 1'b0;
    idle_wait(2);
    if (DB != 0) afront = 1 - afront;
    afill();
    a_en_tran = 1'b1;
    a_refresh = 1'b1;
    @(negedge clk);
    a_refresh = 1'b0;
    k = 0; dones = 0; budget = 0;
    while (k < 4 * ANB && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (a_frame_done === 1'b1) dones++;
      if (a_data_valid === 1'b1) begin
        int kk, pg, ch, cl;
        kk = k % ANB; pg = kk / 8; ch = (kk / 4) % 2; cl = kk % 4;
        obs = {a_data_out, a_page, a_col, a_chip_sel, a_seg_start};
        exp = {amem[afront][kk], 1'(pg), 2'(cl), 2'(1 << ch), cl == 0};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL auto_byte %0d got %h expected %h", k, obs, exp);
        end
        k++;
      end
    end
    @(negedge clk);
    if (a_frame_done === 1'b1) dones++;
    checks++;
    if (dones != 4 || a_busy !== 1'b1 || k != 4 * ANB) begin
      errors++;
      $display("FAIL auto_refresh got frames=%0d bytes=%0d busy=%b expected frames=4 bytes=%0d busy=1",
               dones, k, a_busy, 4 * ANB);
    end
    a_en_tran = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    refresh = 1'b0; swap = 1'b0; en_tran = 1'b0;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_refresh = 1'b0; a_swap = 1'b0; a_en_tran = 1'b0;
    test_reset();
    fill(0);
    do_swap();
    fill(0);
    test_fill_stream();
    test_random_stall();
    test_back_to_back();
    test_abort();
    test_swap();
    test_auto();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
